// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU data port (master) and dmem_responder (slave).
interface dmem_responder_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              req;
    logic [BE_W-1:0]   we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (output req, we, addr, wdata, input  rdata, ack, busy, err);
    modport slave  (input  req, we, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word memory responder: captures one request, waits WAIT cycles, then acks.
// Optional address checking is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [BE_W-1:0]   r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic              r_busy;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [BE_W-1:0]   w_we;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_idx;
    logic              w_err;
    logic              w_enter_resp;

    // With WAIT=0 the response edge is the capture edge, so take the live request in IDLE.
    assign w_we    = (r_state == S_IDLE) ? bus.we    : r_we;
    assign w_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;
    assign w_idx   = w_addr[ADDR_W+1:2];

`ifdef DMEM_ERR_EN
    assign w_err = (w_addr[DATA_W-1:ADDR_W+2] != '0) || (w_addr[1:0] != 2'b00);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{w_addr[DATA_W-1:ADDR_W+2], w_addr[1:0]};
    assign w_err         = 1'b0;
`endif

    assign w_enter_resp = (w_state_nxt == S_RESP);

    // Next-state and wait counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT > 0) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(WAIT - 1);
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_enter_resp;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_err   <= w_enter_resp && w_err;
            if (r_state == S_IDLE && bus.req) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            // A write reports the word as it was before the lane merge.
            if (w_enter_resp) begin
                r_rdata <= w_err ? '0 : r_mem[w_idx];
            end
        end
    end

    // Storage has no reset; reset only blocks the commit.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && !w_err) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (w_we[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.busy  = r_busy;
    assign bus.err   = r_err;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data port: accepts one read or byte-lane write request at a time over a req/ack handshake, holds it for a configurable number of wait states, then commits the write or returns the read word with a single-cycle `ack`. It sits between `mips` and on-chip word storage and stands in for a fixed-latency block RAM. This lets the core be exercised against multi-cycle memory latency.

## Interface
- `ADDR_W`, default 10: word-address width; storage is 2^ADDR_W 32-bit words.
- `WAIT`, default 1: wait states between capture and response, legal range 0..15.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 1: request valid; sampled only in IDLE.
- `we` in 4: byte-lane write enables; 4'b0000 means read.
- `addr` in 32: byte address.
- `wdata` in 32: write data; lane i is bits [8i+7:8i].
- `rdata` out 32: read data, registered, valid in the `ack` cycle and held until the next `ack`.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high in WAIT and RESP.
- `err` out 1: error flag, valid with `ack` (see Configuration).

## Operation
- States are IDLE, WAIT and RESP.
- IDLE with `req`=1 captures `we`, `addr` and `wdata` into internal registers.
  - If `WAIT`>0, the FSM goes to WAIT and loads the down-counter with `WAIT`-1.
  - If `WAIT`=0, the FSM goes directly to RESP.
- IDLE with `req`=0 stays in IDLE.
- WAIT decrements the counter each cycle. When the counter is 0, the FSM goes to RESP.
- On the edge entering RESP:
  - A write updates storage for each asserted lane only. Unasserted lanes keep their old value.
  - A read registers the word at `addr[ADDR_W+1:2]` into `rdata`.
  - `ack` is set to 1.
- For a write, `rdata` returns the pre-write word. Lane merge is done on the registered word.
- RESP lasts exactly one cycle, then the FSM returns to IDLE unconditionally.
- Inputs presented during WAIT or RESP are ignored.
- The requester must hold `req`, `we`, `addr` and `wdata` stable until it sees `ack`. It then either deasserts `req` or presents the next request.
- Counter width is 4 bits. `WAIT` values above 15 are illegal and are not checked.
- Storage is not cleared by reset. Contents are undefined at power-up unless preloaded by the bench.

## Timing
- Reset values: state IDLE, `ack`=0, `busy`=0, `err`=0, `rdata`=32'h0, counter=0.
- Latency: `ack` rises `WAIT`+1 cycles after the cycle in which `req` is sampled in IDLE.
- Throughput: one request per `WAIT`+2 cycles. Back-to-back requests therefore have one IDLE cycle between them.
- Read-after-write to the same word returns the new data, because the write commits on the edge entering RESP, before the next capture.
- Reset has priority over every transition. If `rst` is high on the edge that would enter RESP, no write commits and `ack` stays 0.
- Reset during WAIT aborts the request. No response is ever produced for it.
- `ack` is never high for two consecutive cycles.

## Configuration
- The macro `DMEM_ERR_EN` controls address checking.
- With `DMEM_ERR_EN` defined, a captured request is an error if either holds:
  - `addr[31:ADDR_W+2]` is nonzero, or
  - `addr[1:0]` is not 2'b00.
- An error request still takes the full latency. On completion it performs no write, gives `rdata`=32'h0 and `err`=1 with `ack`.
- Without `DMEM_ERR_EN`:
  - The upper address bits are ignored, so addresses alias modulo 2^ADDR_W words.
  - `addr[1:0]` is ignored.
  - `err` is tied to 0.

## Test plan
- Reset then idle: assert `rst` for 2 cycles, keep `req`=0 for 10 cycles. Outputs must be `ack`=0, `busy`=0, `rdata`=0, `err`=0 throughout.
- Full write then read (`WAIT`=1):
  - Write `we`=4'hF, `addr`=32'h10, `wdata`=32'hDEADBEEF. `ack` must appear exactly 2 cycles after capture.
  - Read `addr`=32'h10 must return 32'hDEADBEEF with `ack`.
- Byte lanes: preload word 4 with 32'h11223344, then write `we`=4'b0101, `wdata`=32'hAABBCCDD. A following read must return 32'h11BB33DD.
- Latency sweep: repeat a read with `WAIT`=0, 3 and 15. `ack` must arrive at 1, 4 and 16 cycles after capture respectively. `busy` must be high for exactly that many cycles, and `ack` must be a single-cycle pulse.
- Reset mid-operation (`WAIT`=3): start a write of 32'h12345678 to `addr`=32'h20 and assert `rst` in the second WAIT cycle. No `ack` may appear. A later read of 32'h20 must return the old contents.
- Error path (`DMEM_ERR_EN`, `ADDR_W`=10):
  - Write to `addr`=32'h1000 must complete with `ack`=1, `err`=1, `rdata`=0, and word 0 unchanged.
  - Read of `addr`=32'h0000_0002 must also give `err`=1.
  - Without the macro, the same write to 32'h1000 must overwrite word 0.
